pixel_store: RTL and testbench

Write-side endpoint of the plot interface (plot, x, y, colour) driven by the game datapath. It commits each plotted pixel into an on-chip colour framebuffer and provides a registered random-access read port, so game logic (collision checks, sprite readback) can read back what has been drawn. A built-in clear engine fills the whole frame with the background colour after reset and on request.

---
 rtl/pixel_store.sv | 92 +++++++++
 tb/tb_pixel_store.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pixel_store.sv
// pixel_store: colour framebuffer behind the plot interface, with a clear engine and a registered read port.
module pixel_store #(
    parameter int                     WIDTH_X      = 9,
    parameter int                     WIDTH_Y      = 8,
    parameter int                     RESOLUTION_X = 320,
    parameter int                     RESOLUTION_Y = 240,
    parameter int                     COLOUR_BITS  = 3,
    parameter logic [COLOUR_BITS-1:0] BG_COLOUR    = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   plot,
    input  logic [WIDTH_X-1:0]     x,
    input  logic [WIDTH_Y-1:0]     y,
    input  logic [COLOUR_BITS-1:0] colour,
    input  logic                   clear,
    output logic                   busy,
    input  logic                   rd_en,
    input  logic [WIDTH_X-1:0]     rd_x,
    input  logic [WIDTH_Y-1:0]     rd_y,
    output logic [COLOUR_BITS-1:0] rd_colour,
    output logic                   rd_valid,
    output logic                   dropped,
    output logic [15:0]            drop_count
);
    localparam int DEPTH = RESOLUTION_X * RESOLUTION_Y;
    localparam int AW    = $clog2(DEPTH);
    typedef enum logic {CLEAR, IDLE} state_t;
    state_t                 state, state_d;
    logic [AW-1:0]          cnt, cnt_d, waddr;
    logic [COLOUR_BITS-1:0] wdata;
    logic                   we, wr_in, rd_in, accept, drop;
    logic [31:0]            wr_full, rd_full;
    logic [COLOUR_BITS-1:0] mem [DEPTH];
    assign wr_full = 32'(y) * 32'(RESOLUTION_X) + 32'(x);
    assign rd_full = 32'(rd_y) * 32'(RESOLUTION_X) + 32'(rd_x);
    // With x in range, address < DEPTH is equivalent to y in range.
    assign wr_in  = (32'(x) < 32'(RESOLUTION_X)) && (wr_full < 32'(DEPTH));
    assign rd_in  = (32'(rd_x) < 32'(RESOLUTION_X)) && (rd_full < 32'(DEPTH));
    assign accept = plot && state == IDLE && !clear && wr_in;
    assign drop   = plot && !accept;
    assign busy   = state == CLEAR;
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        we      = 1'b0;
        waddr   = cnt;
        wdata   = BG_COLOUR;
        if (state == CLEAR) begin
            we    = 1'b1;
            cnt_d = cnt + 1'b1;
            if (cnt == AW'(DEPTH - 1)) state_d = IDLE;
        end else if (clear) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end else if (accept) begin
            we    = 1'b1;
            waddr = wr_full[AW-1:0];
            wdata = colour;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_valid  <= 1'b0;
            rd_colour <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_colour <= rd_in ? mem[rd_full[AW-1:0]] : BG_COLOUR;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            dropped    <= 1'b0;
            drop_count <= '0;
        end else begin
            dropped <= drop;
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_pixel_store.sv
// tb_pixel_store: scoreboard bench for pixel_store on a reduced 20x12 frame.
module tb_pixel_store;
    localparam int RX = 20;
    localparam int RY = 12;
    localparam int D  = RX * RY;
    logic       clock = 0, reset = 1, plot = 0, clear = 0, rd_en = 0;
    logic [8:0] x = 0, rd_x = 0;
    logic [7:0] y = 0, rd_y = 0;
    logic [2:0] colour = 0;
    logic       busy, rd_valid, dropped;
    logic [2:0] rd_colour;
    logic [15:0] drop_count;
    int checks = 0, errors = 0, n = 0;
    logic [2:0]  m [D];
    logic [2:0]  rq [$];
    logic [15:0] dq [$];
    logic [15:0] exp_drops = 0;
    bit          clearing = 1;

    pixel_store #(.RESOLUTION_X(RX), .RESOLUTION_Y(RY)) dut (
        .clock(clock), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
        .clear(clear), .busy(busy), .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
        .rd_colour(rd_colour), .rd_valid(rd_valid), .dropped(dropped), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        plot = 0; clear = 0; rd_en = 0;
    endtask

    task automatic expect_drop();
        if (exp_drops != 16'hFFFF) exp_drops++;
        dq.push_back(exp_drops);
    endtask

    // Drive one cycle of stimulus and record the expected responses before the write lands.
    task automatic op(input bit p, input int px, input int py, input int c,
                      input bit r, input int rx, input int ry, input bit clr);
        bit in_w;
        plot = p; x = 9'(px); y = 8'(py); colour = 3'(c);
        rd_en = r; rd_x = 9'(rx); rd_y = 8'(ry); clear = clr;
        if (r) rq.push_back((rx < RX && ry < RY) ? m[ry*RX+rx] : 3'b000);
        in_w = px < RX && py < RY;
        if (p) begin
            if (!clearing && !clr && in_w) m[py*RX+px] = 3'(c);
            else expect_drop();
        end
        if (clr && !clearing) begin
            clearing = 1;
            foreach (m[i]) m[i] = 3'b000;
        end
        step();
        idle_inputs();
    endtask

    task automatic rd(input int rx, input int ry);
        op(0, 0, 0, 0, 1, rx, ry, 0);
    endtask

    // Count busy cycles; optionally inject a plot (+clear) at cycle inj.
    task automatic fill_wait(input string name, input int inj, input bit inj_clr);
        n = 0;
        while (busy && n < 4 * D) begin
            if (n == inj) begin
                plot = 1; x = 9'd3; y = 8'd3; colour = 3'd1; clear = inj_clr;
                expect_drop();
            end
            step();
            idle_inputs();
            n++;
        end
        chk(name, n, D);
        clearing = 0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", int'(busy), 1);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_colour", int'(rd_colour), 0);
        chk("rst_dropped", int'(dropped), 0);
        chk("rst_drop_count", int'(drop_count), 0);
    endtask

    always @(negedge clock) begin
        if (rd_valid) begin
            if (rq.size() == 0) chk("unexpected_rd_valid", 1, 0);
            else chk("rd_colour", int'(rd_colour), int'(rq.pop_front()));
        end
        if (dropped) begin
            if (dq.size() == 0) chk("unexpected_dropped", 1, 0);
            else chk("drop_count", int'(drop_count), int'(dq.pop_front()));
        end
    end

    initial begin
        foreach (m[i]) m[i] = 3'b000;
        step(); step();
        chk_reset_vals();
        reset = 0;
        fill_wait("fill_after_reset", 5, 0);
        rd(0, 0); rd(RX-1, RY-1); rd(RX/2, RY/2);
        op(1, 5, 7, 5, 0, 0, 0, 0);
        rd(5, 7); rd(6, 7);
        op(1, 10, 10, 3, 1, 10, 10, 0);
        rd(10, 10);
        op(1, RX, 0, 6, 0, 0, 0, 0);
        op(1, 0, RY, 6, 0, 0, 0, 0);
        rd(0, 0); rd(RX, 3); rd(0, RY);
        op(1, 19, 11, 7, 1, 19, 11, 0);
        rd(19, 11); rd(5, 7);
        op(1, 2, 2, 6, 0, 0, 0, 1);
        chk("busy_after_clear", int'(busy), 1);
        fill_wait("fill_after_clear", 100, 1);
        rd(5, 7); rd(10, 10); rd(2, 2); rd(19, 11); rd(3, 3); rd(0, 0);
        op(1, 19, 11, 7, 0, 0, 0, 0);
        rd(19, 11);
        op(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (D / 2) step();
        reset = 1;
        step();
        chk_reset_vals();
        reset = 0;
        exp_drops = 0;
        foreach (m[i]) m[i] = 3'b000;
        clearing = 1;
        fill_wait("fill_after_midreset", -1, 0);
        chk("drop_count_after_reset", int'(drop_count), 0);
        op(1, 1, 1, 2, 0, 0, 0, 0);
        rd(1, 1); rd(19, 11);
        step(); step();
        chk("rd_queue_empty", rq.size(), 0);
        chk("drop_queue_empty", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
